e203_exu_fpu_fmac_ctrl: RTL and testbench
=========================================

Name: e203_exu_fpu_fmac_ctrl

Overview:
Sequencing controller in front of the multi-cycle single-precision fused multiply-add datapath (rs1*rs2+rs3, variable latency). It accepts one FMA-class op from the FPU dispatch, decodes MADD/MSUB/NMSUB/NMADD into sign-adjusted operands, and holds them stable with datapath valid asserted until the datapath completes. It then buffers the result with its instruction tag for the writeback arbiter and supports pipeline flush of an in-flight op.

Parameters:
ITAG_W, 1, width of instruction tag carried alongside the op
TIMEOUT_CYC, 255, max cycles in RUN before watchdog abort (used only with the optional feature)
CNT_W, 8, width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  dispatch request valid
i_ready  out  1  controller can accept
i_op  in  2  00 MADD, 01 MSUB, 10 NMSUB, 11 NMADD
i_rs1, i_rs2, i_rs3  in  32 each  IEEE-754 single operands
i_itag  in  ITAG_W  instruction tag
flush  in  1  kill any accepted, not-yet-delivered op
o_valid  out  1  result valid to writeback
o_ready  in  1  writeback accepts
o_wdat  out  32  result
o_itag  out  ITAG_W  tag of result
o_err  out  1  result produced by watchdog abort
dp_i_valid  out  1  datapath request valid
dp_i_ready  in  1  datapath accept/complete strobe
dp_rs1, dp_rs2, dp_rs3  out  32 each  sign-adjusted operands
dp_o_valid  in  1  datapath result valid
dp_o_ready  out  1  controller accepts datapath result
dp_wdat  in  32  datapath result
busy  out  1  state != IDLE

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. Reset clears all state regardless of the current state, including mid-RUN. State returns to IDLE. o_valid=0, o_err=0, dp_i_valid=0, o_wdat=0, o_itag=0, dp_rs*=0, and the kill flag and counter are cleared.
- States: IDLE, RUN, GAP, HOLD.
- IDLE: i_ready=1. When i_valid, and flush is low, latch operands and itag, then go to RUN on the next cycle.
  - Operand decode: MADD passes operands through. MSUB flips rs3[31]. NMSUB flips rs1[31]. NMADD flips rs1[31] and rs3[31].
  - If i_valid and flush are both high, the request is not accepted.
- RUN: dp_i_valid=1 and dp_o_ready=1. dp_rs* are registered and must not change while in RUN.
  - Completion is the cycle where dp_o_valid & dp_i_ready is high. On completion, capture dp_wdat into o_wdat and go to GAP.
- GAP: exactly one cycle with dp_i_valid=0, which guarantees the datapath sees a low valid between ops.
  - Next state is HOLD, or IDLE if the op was killed.
- HOLD: o_valid=1, with o_wdat/o_itag/o_err stable. Return to IDLE when o_ready. The next op can be accepted in the cycle after that return.
- i_ready is high only in IDLE, so one op is in flight at a time.
- Minimum latency is accept cycle + datapath latency + 2 (GAP and the first HOLD cycle).
- Flush in RUN: the datapath cannot be aborted. Set the kill flag, let the op run to completion, then discard the result (GAP -> IDLE, o_valid never rises). A flush in GAP does the same.
- Flush in HOLD: drop o_valid next cycle and go to IDLE, even if o_ready is high in the same cycle. Flush has priority over delivery.
- Flush in IDLE: no effect.
- dp_o_valid outside RUN is ignored.
- busy is high in RUN, GAP and HOLD.

Optional Feature:
FMAC_CTRL_TIMEOUT_EN
- Defined: a CNT_W counter clears on entry to RUN and increments each RUN cycle. When it reaches TIMEOUT_CYC without completion, force a canonical NaN 0x7FC00000 into o_wdat, set o_err=1 and go to GAP. GAP lasts one cycle, then the controller waits in GAP until dp_i_ready is low before advancing.
  - The kill flag still suppresses delivery.
  - o_err clears on the handshake out of HOLD.
- Undefined: no counter is present, o_err is tied 0, and RUN waits indefinitely.

Test Plan:
- MADD 0x40000000, 0x40400000, 0x3F800000 (2.0, 3.0, 1.0) -> dp_rs unchanged, o_wdat=0x40E00000 (7.0), o_itag matches, o_err=0.
- MSUB same operands -> dp_rs3=0xBF800000, o_wdat=0x40A00000. NMSUB -> dp_rs1=0xC0000000, o_wdat=0xC0A00000. NMADD -> both flipped, o_wdat=0xC0E00000.
- Backpressure: hold o_ready=0 for 10 cycles in HOLD -> o_valid stays 1 with stable data, i_ready=0 throughout; o_ready=1 -> IDLE next cycle; dp_i_valid low ≥1 cycle between back-to-back ops.
- Flush mid-RUN at cycle 5 of the op -> operands stay stable until completion, o_valid never asserts, busy drops after GAP; the next op completes correctly.
- Flush in HOLD with o_ready=1 in the same cycle -> no result delivered, IDLE next cycle. Async reset asserted mid-RUN -> all outputs 0 immediately, IDLE after release.
- With FMAC_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, stub datapath never completes -> after 16 RUN cycles o_valid=1, o_wdat=0x7FC00000, o_err=1.

Source files
------------

// File: rtl/e203_exu_fpu_fmac_ctrl.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_fmac_ctrl
//
// Sequencing controller in front of the multi-cycle single-precision fused
// multiply-add datapath (rs1*rs2+rs3). It accepts one FMA-class op at a time,
// folds the MADD/MSUB/NMSUB/NMADD variants into operand sign flips, holds the
// operands and dp_i_valid steady until the datapath completes, then parks the
// result and its tag for the writeback arbiter. A flush kills the op in flight.
//
// Optional feature macro: FMAC_CTRL_TIMEOUT_EN
//   Defined   : a RUN watchdog aborts after TIMEOUT_CYC cycles with a canonical
//               NaN result and o_err=1.
//   Undefined : no watchdog, o_err is tied low, RUN waits indefinitely.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_valid/i_ready         dispatch handshake (i_ready only in IDLE)
//   i_op                    00 MADD, 01 MSUB, 10 NMSUB, 11 NMADD
//   i_rs1/i_rs2/i_rs3       IEEE-754 single operands
//   i_itag                  instruction tag
//   flush                   kill any accepted, not-yet-delivered op
//   o_valid/o_ready         writeback handshake
//   o_wdat/o_itag/o_err     result, its tag, watchdog-abort marker
//   dp_i_valid/dp_i_ready   datapath request / accept-complete strobe
//   dp_rs1/dp_rs2/dp_rs3    sign-adjusted operands to the datapath
//   dp_o_valid/dp_o_ready   datapath result handshake
//   dp_wdat                 datapath result
//   busy                    controller is not IDLE
// ---------------------------------------------------------------------------
module e203_exu_fpu_fmac_ctrl #(
  parameter int ITAG_W      = 1,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [1:0]        i_op,
  input  logic [31:0]       i_rs1,
  input  logic [31:0]       i_rs2,
  input  logic [31:0]       i_rs3,
  input  logic [ITAG_W-1:0] i_itag,
  input  logic              flush,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [31:0]       o_wdat,
  output logic [ITAG_W-1:0] o_itag,
  output logic              o_err,
  output logic              dp_i_valid,
  input  logic              dp_i_ready,
  output logic [31:0]       dp_rs1,
  output logic [31:0]       dp_rs2,
  output logic [31:0]       dp_rs3,
  input  logic              dp_o_valid,
  output logic              dp_o_ready,
  input  logic [31:0]       dp_wdat,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // The watchdog counter must be able to represent TIMEOUT_CYC.
  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cfgCheck
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  logic [1:0]        r_state;
  logic              r_kill;
  logic [31:0]       r_rs1;
  logic [31:0]       r_rs2;
  logic [31:0]       r_rs3;
  logic [31:0]       r_wdat;
  logic [ITAG_W-1:0] r_itag;

  logic w_accept;
  logic w_done;
  logic w_flip1;
  logic w_flip3;
  logic w_gapGo;
  logic w_timeout;

  assign w_accept = (r_state == ST_IDLE) && i_valid && !flush;
  assign w_done   = (r_state == ST_RUN) && dp_o_valid && dp_i_ready;

  // The negated forms (op[1]) flip the product sign via rs1; the subtracting
  // forms (op[0]) flip the addend sign via rs3.
  assign w_flip1 = i_op[1];
  assign w_flip3 = i_op[0];

`ifdef FMAC_CTRL_TIMEOUT_EN
  localparam logic [31:0] LP_CANON_NAN = 32'h7FC0_0000;

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // r_cnt holds the number of RUN cycles already elapsed, so the abort fires
  // in the TIMEOUT_CYC-th RUN cycle. Completion in that cycle still wins.
  assign w_timeout = (r_state == ST_RUN) && !w_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // After an abort the datapath may still be strobing; leave GAP only once
  // dp_i_ready has dropped so the next op starts clean.
  assign w_gapGo   = !r_err || !dp_i_ready;
  assign o_err     = r_err;

  // Watchdog counter: cleared on entry to RUN, counts every RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Error flag travels with the aborted result and clears when it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if ((r_state == ST_HOLD) && (o_ready || flush)) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_GAP) && w_gapGo && (r_kill || flush)) begin
      r_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_gapGo   = 1'b1;
  assign o_err     = 1'b0;
`endif

  // Main sequencer: IDLE accepts, RUN waits on the datapath, GAP forces one
  // low dp_i_valid cycle, HOLD presents the result until taken or flushed.
  // A flush during RUN/GAP only marks the op killed, since the datapath
  // cannot be aborted; the result is then dropped on the way out of GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_kill  <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rs3   <= '0;
      r_wdat  <= '0;
      r_itag  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rs1   <= {i_rs1[31] ^ w_flip1, i_rs1[30:0]};
            r_rs2   <= i_rs2;
            r_rs3   <= {i_rs3[31] ^ w_flip3, i_rs3[30:0]};
            r_itag  <= i_itag;
            r_kill  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            r_kill <= 1'b1;
          end
          if (w_done) begin
            r_wdat  <= dp_wdat;
            r_state <= ST_GAP;
          end
`ifdef FMAC_CTRL_TIMEOUT_EN
          else if (w_timeout) begin
            r_wdat  <= LP_CANON_NAN;
            r_state <= ST_GAP;
          end
`endif
        end
        ST_GAP: begin
          if (flush) begin
            r_kill <= 1'b1;
          end
          if (w_gapGo) begin
            r_state <= (r_kill || flush) ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Flush outranks delivery; either way the slot empties.
          if (flush || o_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign i_ready    = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign dp_i_valid = (r_state == ST_RUN);
  assign dp_o_ready = (r_state == ST_RUN);
  assign o_valid    = (r_state == ST_HOLD);
  assign dp_rs1     = r_rs1;
  assign dp_rs2     = r_rs2;
  assign dp_rs3     = r_rs3;
  assign o_wdat     = r_wdat;
  assign o_itag     = r_itag;

endmodule

// File: tb/tb_e203_exu_fpu_fmac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_fpu_fmac_ctrl
//
// Directed bench for the FMA sequencing controller. A stub datapath with a
// programmable latency computes rs1*rs2+rs3 from whatever operands the DUT
// presents. An independent model derives, from the architectural meaning of
// each op, the operands the datapath must see, the result that must come back
// and which cycle-level phase the controller must be in; it is compared
// against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_e203_exu_fpu_fmac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid;
  logic        i_ready;
  logic [1:0]  i_op;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] i_rs3;
  logic [0:0]  i_itag;
  logic        flush;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_wdat;
  logic [0:0]  o_itag;
  logic        o_err;
  logic        dp_i_valid;
  logic        dp_i_ready;
  logic [31:0] dp_rs1;
  logic [31:0] dp_rs2;
  logic [31:0] dp_rs3;
  logic        dp_o_valid;
  logic        dp_o_ready;
  logic [31:0] dp_wdat;
  logic        busy;

  always #5 clk = ~clk;

  e203_exu_fpu_fmac_ctrl #(.ITAG_W(1), .TIMEOUT_CYC(255), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs3(i_rs3), .i_itag(i_itag),
    .flush(flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_itag(o_itag), .o_err(o_err),
    .dp_i_valid(dp_i_valid), .dp_i_ready(dp_i_ready),
    .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rs3(dp_rs3),
    .dp_o_valid(dp_o_valid), .dp_o_ready(dp_o_ready), .dp_wdat(dp_wdat),
    .busy(busy)
  );

  int checkCount = 0;
  int errorCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Single-precision <-> real conversion, normal numbers and zero only.
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Architectural meaning of the four ops.
  function automatic logic [31:0] fmaModel(input logic [1:0] op, input logic [31:0] a, b, c);
    real p, s, r;
    p = sp2r(a) * sp2r(b);
    s = sp2r(c);
    case (op)
      2'b00:   r = p + s;
      2'b01:   r = p - s;
      2'b10:   r = -p + s;
      default: r = -p - s;
    endcase
    return r2sp(r);
  endfunction

  // Stub datapath: completes in its stubLat-th cycle of seeing dp_i_valid.
  int stubLat = 1;
  int runCycles = 0;
  bit spurious = 1'b0;

  initial begin
    dp_o_valid = 1'b0;
    dp_i_ready = 1'b0;
    dp_wdat    = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (dp_i_valid) begin
        runCycles++;
        if (runCycles == stubLat) begin
          dp_o_valid = 1'b1;
          dp_i_ready = 1'b1;
          dp_wdat    = r2sp(sp2r(dp_rs1) * sp2r(dp_rs2) + sp2r(dp_rs3));
        end else begin
          dp_o_valid = 1'b0;
          dp_i_ready = 1'b0;
        end
      end else begin
        runCycles  = 0;
        dp_o_valid = spurious;
        dp_i_ready = spurious;
        dp_wdat    = spurious ? 32'hDEAD_BEEF : 32'd0;
      end
    end
  end

  // Model: phase 0 idle, 1 datapath busy, 2 spacer, 3 result offered.
  int          mPhase = 0;
  bit          mKilled = 1'b0;
  int          mDelivered = 0;
  logic [31:0] mRs1, mRs2, mRs3, mWdat;
  logic        mTag;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mPhase  = 0;
        mKilled = 1'b0;
      end else begin
        checkOutput("ctrl{busy,i_ready,dp_i_valid,dp_o_ready,o_valid,o_err}",
                    {26'd0, busy, i_ready, dp_i_valid, dp_o_ready, o_valid, o_err},
                    {26'd0, mPhase != 0, mPhase == 0, mPhase == 1, mPhase == 1, mPhase == 3, 1'b0});
        if (mPhase == 1) begin
          checkOutput("run_dp_rs1", dp_rs1, mRs1);
          checkOutput("run_dp_rs2", dp_rs2, mRs2);
          checkOutput("run_dp_rs3", dp_rs3, mRs3);
        end
        if (mPhase == 3) begin
          checkOutput("hold_wdat", o_wdat, mWdat);
          checkOutput("hold_itag", {31'd0, o_itag}, {31'd0, mTag});
        end
        case (mPhase)
          0: if (i_valid && !flush) begin
               mRs1    = i_op[1] ? {~i_rs1[31], i_rs1[30:0]} : i_rs1;
               mRs2    = i_rs2;
               mRs3    = i_op[0] ? {~i_rs3[31], i_rs3[30:0]} : i_rs3;
               mWdat   = fmaModel(i_op, i_rs1, i_rs2, i_rs3);
               mTag    = i_itag[0];
               mKilled = 1'b0;
               mPhase  = 1;
             end
          1: begin
               if (flush) mKilled = 1'b1;
               if (dp_o_valid && dp_i_ready) mPhase = 2;
             end
          2: begin
               if (flush) mKilled = 1'b1;
               mPhase = mKilled ? 0 : 3;
             end
          default: if (flush || o_ready) begin
               if (!flush) mDelivered++;
               mPhase = 0;
             end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, b, c,
                               input logic tag, input int lat);
    int k;
    stubLat = lat;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_rs3   = c;
    i_itag  = tag;
    i_valid = 1'b1;
    k = 0;
    while (!i_ready && k < 50) begin
      tick();
      k++;
    end
    if (!i_ready) checkOutput("accept_timeout", {31'd0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic waitOutput(input string name);
    int k;
    k = 0;
    while (!o_valid && k < 100) begin
      tick();
      k++;
    end
    checkOutput({name, "_seen"}, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic deliver();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  logic [1:0]  tblOp   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [31:0] tblRs1  [4] = '{32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'hC000_0000};
  logic [31:0] tblRs3  [4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000};
  logic [31:0] tblWdat [4] = '{32'h40E0_0000, 32'h40A0_0000, 32'hC0A0_0000, 32'hC0E0_0000};
  int          tblLat  [4] = '{3, 1, 5, 2};

  initial begin
    bit sawValid;
    int k;
    i_valid = 1'b0; i_op = 2'b00; i_rs1 = '0; i_rs2 = '0; i_rs3 = '0; i_itag = '0;
    flush = 1'b0; o_ready = 1'b0;

    // Reset values.
    #12;
    checkOutput("rst_o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_dp_i_valid", {31'd0, dp_i_valid}, 32'd0);
    checkOutput("rst_i_ready", {31'd0, i_ready}, 32'd1);
    checkOutput("rst_o_wdat", o_wdat, 32'd0);
    checkOutput("rst_dp_rs1", dp_rs1, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pin the model to hand-computed results.
    for (int i = 0; i < 4; i++)
      checkOutput("model_pin", fmaModel(tblOp[i], 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000), tblWdat[i]);

    // The four op variants, back to back; the first sits in HOLD for 10 cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tblOp[i], 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, i[0], tblLat[i]);
      checkOutput("op_dp_rs1", dp_rs1, tblRs1[i]);
      checkOutput("op_dp_rs3", dp_rs3, tblRs3[i]);
      waitOutput("op");
      checkOutput("op_wdat", o_wdat, tblWdat[i]);
      checkOutput("op_itag", {31'd0, o_itag}, {31'd0, i[0]});
      if (i == 0) begin
        repeat (10) tick();
        checkOutput("bp_o_valid", {31'd0, o_valid}, 32'd1);
        checkOutput("bp_i_ready", {31'd0, i_ready}, 32'd0);
      end
      deliver();
      checkOutput("op_idle_after", {31'd0, busy}, 32'd0);
    end

    // Flush in RUN cycle 5 of a 10-cycle op: result must vanish.
    applyStimulus(2'b00, 32'h3FC0_0000, 32'h4080_0000, 32'h3F00_0000, 1'b1, 10);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sawValid = 1'b0;
    k = 0;
    while (busy && k < 30) begin
      if (o_valid) sawValid = 1'b1;
      tick();
      k++;
    end
    checkOutput("flush_run_no_valid", {31'd0, sawValid}, 32'd0);
    checkOutput("flush_run_idle", {31'd0, busy}, 32'd0);

    // Next op after the killed one completes normally.
    applyStimulus(2'b00, 32'h3FC0_0000, 32'h4080_0000, 32'h3F00_0000, 1'b0, 4);
    waitOutput("post_flush");
    checkOutput("post_flush_wdat", o_wdat, 32'h40D0_0000);
    deliver();

    // Flush during the GAP cycle.
    applyStimulus(2'b11, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 1'b1, 2);
    tick();
    tick();
    checkOutput("gap_reached", {30'd0, busy, dp_i_valid}, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_gap_idle", {30'd0, busy, o_valid}, 32'd0);

    // Flush in HOLD together with o_ready: nothing delivered.
    applyStimulus(2'b01, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 1'b0, 3);
    waitOutput("hold_flush");
    flush = 1'b1;
    o_ready = 1'b1;
    tick();
    flush = 1'b0;
    o_ready = 1'b0;
    checkOutput("flush_hold_idle", {30'd0, busy, o_valid}, 32'd0);

    // Flush in IDLE blocks the simultaneous request.
    i_op = 2'b00; i_rs1 = 32'h4000_0000; i_itag = 1'b1;
    i_valid = 1'b1;
    flush = 1'b1;
    tick();
    i_valid = 1'b0;
    flush = 1'b0;
    checkOutput("idle_flush_not_accepted", {31'd0, busy}, 32'd0);

    // A datapath result outside RUN is ignored.
    spurious = 1'b1;
    tick();
    tick();
    spurious = 1'b0;
    tick();
    checkOutput("spurious_ignored", {30'd0, busy, o_valid}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(2'b11, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 1'b1, 20);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_dp_i_valid", {31'd0, dp_i_valid}, 32'd0);
    checkOutput("arst_dp_rs1", dp_rs1, 32'd0);
    checkOutput("arst_dp_rs3", dp_rs3, 32'd0);
    checkOutput("arst_o_itag", {31'd0, o_itag}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("arst_idle", {30'd0, busy, i_ready}, 32'd1);

    // Minimum datapath latency after reset.
    applyStimulus(2'b10, 32'h3FC0_0000, 32'h4080_0000, 32'h3F00_0000, 1'b1, 1);
    waitOutput("final");
    checkOutput("final_wdat", o_wdat, 32'hC0B0_0000);
    deliver();
    tick();

    checkOutput("delivered_count", mDelivered, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
